// File: rtl/md_unit_e_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: md_op encodings,
// default latencies and the run-state enum. The E-stage decoder uses the same
// md_op constants.
package md_unit_e_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam logic [3:0] MD_RSV9  = 4'd9;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for the ops that launch a multi-cycle mult/div.
  function automatic logic is_md_start_op(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_e_arith.sv
// Combinational 64-bit product / quotient-remainder generator for mult, multu,
// div and divu. Signed division is done on magnitudes so the most-negative
// dividend over -1 wraps to 0x80000000 with a zero remainder instead of
// overflowing.
module md_unit_e_arith
  import md_unit_e_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_div0
);

  logic signed [2*DATA_W-1:0] w_a_sext;
  logic signed [2*DATA_W-1:0] w_b_sext;
  logic signed [2*DATA_W-1:0] w_prod_s;
  logic        [2*DATA_W-1:0] w_prod_u;
  logic        [DATA_W-1:0]   w_a_mag;
  logic        [DATA_W-1:0]   w_b_mag;
  logic        [DATA_W-1:0]   w_b_mag_safe;
  logic        [DATA_W-1:0]   w_b_safe;
  logic        [DATA_W-1:0]   w_q_mag;
  logic        [DATA_W-1:0]   w_r_mag;
  logic        [DATA_W-1:0]   w_q_s;
  logic        [DATA_W-1:0]   w_r_s;
  logic        [DATA_W-1:0]   w_q_u;
  logic        [DATA_W-1:0]   w_r_u;

  assign w_a_sext = {{DATA_W{i_a[DATA_W-1]}}, i_a};
  assign w_b_sext = {{DATA_W{i_b[DATA_W-1]}}, i_b};
  assign w_prod_s = w_a_sext * w_b_sext;
  assign w_prod_u = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

  // A zero divisor is replaced by 1 so the dividers never see 0; the result
  // is discarded by the caller via o_div0.
  assign w_a_mag      = i_a[DATA_W-1] ? (~i_a + 1'b1) : i_a;
  assign w_b_mag      = i_b[DATA_W-1] ? (~i_b + 1'b1) : i_b;
  assign w_b_mag_safe = (w_b_mag == '0) ? DATA_W'(1) : w_b_mag;
  assign w_b_safe     = (i_b == '0) ? DATA_W'(1) : i_b;
  assign w_q_mag      = w_a_mag / w_b_mag_safe;
  assign w_r_mag      = w_a_mag % w_b_mag_safe;
  assign w_q_s        = (i_a[DATA_W-1] ^ i_b[DATA_W-1]) ? (~w_q_mag + 1'b1) : w_q_mag;
  assign w_r_s        = i_a[DATA_W-1] ? (~w_r_mag + 1'b1) : w_r_mag;
  assign w_q_u        = i_a / w_b_safe;
  assign w_r_u        = i_a % w_b_safe;

  // Select the result pair for the requested op.
  always_comb begin
    o_hi   = '0;
    o_lo   = '0;
    o_div0 = 1'b0;
    case (i_op)
      MD_MULT:  {o_hi, o_lo} = w_prod_s;
      MD_MULTU: {o_hi, o_lo} = w_prod_u;
      MD_DIV: begin
        o_hi   = w_r_s;
        o_lo   = w_q_s;
        o_div0 = (i_b == '0);
      end
      MD_DIVU: begin
        o_hi   = w_r_u;
        o_lo   = w_q_u;
        o_div0 = (i_b == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_e.sv
// E-stage multiply/divide unit: owns HI/LO, models mult/div latency with a
// down-counter, and supplies mfhi/mflo to the E-stage result mux.
module md_unit_e
  import md_unit_e_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        start,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e          r_state;
  md_state_e          w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_pend_hi;
  logic [31:0]        r_pend_lo;
  logic               r_pend_div0;
  logic               w_start;
  logic               w_done;
  logic               w_is_mult;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;
  logic               w_div0;

  md_unit_e_arith #(.DATA_W(32)) u_arith (
    .i_op   (md_op),
    .i_a    (rs_data),
    .i_b    (rt_data),
    .o_hi   (w_res_hi),
    .o_lo   (w_res_lo),
    .o_div0 (w_div0)
  );

  assign w_start   = is_md_start_op(md_op) && (r_state == ST_IDLE);
  assign w_is_mult = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign start     = w_start;
  assign busy      = (r_state == ST_RUN);
  assign hi        = r_hi;
  assign lo        = r_lo;

  // Next-state logic: launch on start, finish when the counter reaches 1.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start)
        r_cnt <= w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      else if (r_state == ST_RUN)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // Pending result captured from the operands present at the launch edge.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_pend_hi   <= w_res_hi;
      r_pend_lo   <= w_res_lo;
      r_pend_div0 <= w_div0;
    end
  end

  // Committed HI/LO: completion writes the pending pair unless the divisor was
  // zero; mthi/mtlo write directly, but only while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      if (!r_pend_div0) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (r_state == ST_IDLE) begin
      if (md_op == MD_MTHI) r_hi <= rs_data;
      if (md_op == MD_MTLO) r_lo <= rs_data;
    end
  end

  // mfhi/mflo read path returns committed values, even while busy.
  always_comb begin
    md_out = '0;
    if (md_op == MD_MFHI) md_out = r_hi;
    else if (md_op == MD_MFLO) md_out = r_lo;
  end

endmodule

// File: tb/tb_md_unit_e.sv
// Scoreboard bench for md_unit_e: stimulus queues expected HI/LO/latency and
// mfhi/mflo values; a negedge monitor pops and compares when the DUT finishes
// an operation or presents a read.
module tb_md_unit_e;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        start;
  logic        busy;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;
  int          busy_cnt = 0;
  logic        prev_busy = 1'b0;
  logic        abort = 1'b0;

  always #5 clk = ~clk;

  md_unit_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .start   (start),
    .busy    (busy),
    .md_out  (md_out),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: completion and read checks, plus hazard-violation detection.
  always @(negedge clk) begin
    exp_t e;
    if (busy && reset) abort = 1'b1;
    if (busy && !reset && (md_op >= 4'd1) && (md_op <= 4'd8)) begin
      checks++;
      errors++;
      $display("FAIL hazard: md_op %0d issued while busy", md_op);
    end
    if ((md_op == 4'd5) || (md_op == 4'd6)) begin
      if (rd_q.size() > 0) chk("md_out", md_out, rd_q.pop_front());
      else begin
        checks++;
        errors++;
        $display("FAIL md_out: unexpected read, got 0x%08h", md_out);
      end
    end
    if (busy) busy_cnt++;
    else if (prev_busy) begin
      if (abort) begin
        abort = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL completion: no expectation queued, hi 0x%08h lo 0x%08h", hi, lo);
      end else begin
        e = exp_q.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("busy_cycles", 32'(busy_cnt), 32'(e.cyc));
      end
      busy_cnt = 0;
    end
    prev_busy = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic exp_start);
    md_op   = op;
    rs_data = a;
    rt_data = b;
    #1;
    chk("start", {31'b0, start}, {31'b0, exp_start});
    tick();
    md_op = 4'd0;
  endtask

  task automatic read(input logic [3:0] op, input logic [31:0] exp);
    rd_q.push_back(exp);
    md_op = op;
    tick();
    md_op = 4'd0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int cyc);
    exp_t e;
    e.hi = ehi;
    e.lo = elo;
    e.cyc = cyc;
    exp_q.push_back(e);
    issue(op, a, b, 1'b1);
    wait_idle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    md_op   = 4'd0;
    rs_data = '0;
    rt_data = '0;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_start", {31'b0, start}, 32'h0);
    read(4'd5, 32'h0);

    run_op(4'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    run_op(4'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5);
    run_op(4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
    run_op(4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10);
    run_op(4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10);

    issue(4'd7, 32'h12345678, 32'h0, 1'b0);
    chk("mthi_busy", {31'b0, busy}, 32'h0);
    issue(4'd8, 32'h9ABCDEF0, 32'h0, 1'b0);
    chk("mtlo_busy", {31'b0, busy}, 32'h0);
    read(4'd5, 32'h12345678);
    read(4'd6, 32'h9ABCDEF0);

    issue(4'd7, 32'h00000011, 32'h0, 1'b0);
    issue(4'd8, 32'h00000022, 32'h0, 1'b0);
    run_op(4'd4, 32'd7, 32'd0, 32'h00000011, 32'h00000022, 10);
    chk("div0_hi", hi, 32'h00000011);
    chk("div0_lo", lo, 32'h00000022);

    begin
      exp_t e;
      e.hi = 32'h0;
      e.lo = 32'd12;
      e.cyc = 5;
      exp_q.push_back(e);
    end
    issue(4'd1, 32'd3, 32'd4, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_busy", {31'b0, busy}, 32'h0);
    chk("midreset_hi", hi, 32'h0);
    chk("midreset_lo", lo, 32'h0);
    tick();
    run_op(4'd1, 32'd3, 32'd4, 32'h0, 32'd12, 5);

    repeat (3) tick();
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit_e.md
Name: md_unit_e

Overview:
- E-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Directly downstream of the E-stage control decoder: consumes its 4-bit md_op plus the forwarded rs/rt operands.
- Owns the HI/LO registers and models multi-cycle mult/div latency with start/busy.
- Provides the mfhi/mflo read value to the E-stage result mux.
- The D-stage hazard logic uses start|busy to stall any md-class instruction.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- md_op  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 reserved; 10-15 reserved
- rs_data  input  32  forwarded rs operand
- rt_data  input  32  forwarded rt operand
- start  output  1  combinational; high when md_op is 1-4 and busy is low
- busy  output  1  registered; high while an operation is in flight
- md_out  output  32  combinational; HI when md_op=5, LO when md_op=6, else 0
- hi  output  32  committed HI, for debug
- lo  output  32  committed LO, for debug

Behaviour:
- Reset, taking effect at the clock edge: HI=0, LO=0, busy=0, counter=0, state=IDLE. Reset has priority over everything, including a start in the same cycle.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE -> RUN: on the edge where start=1.
  - The result is computed from rs_data/rt_data sampled at that edge into pending_hi/pending_lo.
  - counter is loaded with MULT_CYCLES or DIV_CYCLES.
- RUN:
  - counter decrements each edge.
  - On the edge where counter==1: HI/LO <= pending (except div-by-zero, see below), busy falls, state=IDLE.
  - Net timing: start sampled at edge T; busy=1 for cycles after edge T through edge T+N; HI/LO valid from edge T+N.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit product of rs*rt.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = signed quotient, truncated toward zero; HI = remainder, sign follows dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divisor 0 (div or divu): still busy for DIV_CYCLES; HI and LO are left unchanged at completion.
- mthi/mtlo (md_op 7/8) in IDLE: HI or LO <= rs_data at the edge, no busy.
- md_op 0, 9-15: no state change.
- md_op 1-8 arriving while busy=1 is excluded by the hazard logic.
  - If it occurs anyway: ignored, with no change to HI, LO or the running operation.
  - The bench flags it as a violation.
- mfhi/mflo while busy: md_out still returns the committed (old) HI/LO. The stall upstream guarantees correctness.
- E-stage bubbles present md_op=0, so a flush never aborts an in-flight operation. Only reset does.

Decomposition:
- Shared package holds:
  - md_op encodings: MD_NONE..MD_MTLO, MD_RSV9.
  - MULT_CYCLES and DIV_CYCLES defaults.
  - The 2-state enum.
- The same md_op constants replace the literals in the E-stage decoder.
- One sub-module is natural: md_arith, a purely combinational 64-bit signed/unsigned product and quotient/remainder generator selected by op. It is instantiated once.
- The FSM, counter and HI/LO stay in md_unit_e.

Test Plan:
- Reset then idle:
  - hi=lo=0, busy=0, start=0.
  - md_op=5 -> md_out=0x00000000.
- mult, rs=0xFFFFFFFF, rt=0x00000002:
  - start=1 for one cycle, then busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div, rs=0xFFFFFFF9 (-7), rt=2:
  - busy=1 for 10 cycles.
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi rs=0x12345678, then mtlo rs=0x9ABCDEF0:
  - md_op=5 -> md_out=0x12345678.
  - md_op=6 -> md_out=0x9ABCDEF0.
  - busy never asserts.
- divu, rs=7, rt=0, with hi/lo preloaded to 0x11/0x22:
  - busy=1 for 10 cycles.
  - Afterwards hi=0x11, lo=0x22.
- Reset mid-operation:
  - Assert reset on the 3rd busy cycle of a mult -> next cycle busy=0, hi=lo=0.
  - A subsequent mult completes normally.
